// File: rtl/maxnet_pkg.sv
// Shared types and constants for the MAXNET neuron data memory.
package maxnet_pkg;

  localparam int unsigned DefaultDataW = 32;

  typedef enum logic [1:0] {
    StLoad,
    StRun,
    StSync
  } state_e;

endpackage

// File: rtl/maxnet_dm_bank.sv
// One DEPTH x DATA_W activation bank: NUM_CH write ports, one copy/load write port,
// NUM_CH registered read ports and a flat view of the whole array.
module maxnet_dm_bank
  import maxnet_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned AW     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        wr_en_i,
  input  logic [NUM_CH*AW-1:0]     wr_addr_i,
  input  logic [NUM_CH*DATA_W-1:0] wr_data_i,
  input  logic                     cp_en_i,
  input  logic [AW-1:0]            cp_addr_i,
  input  logic [DATA_W-1:0]        cp_data_i,
  input  logic [NUM_CH*AW-1:0]     rd_addr_i,
  output logic [NUM_CH*DATA_W-1:0] rd_data_o,
  output logic [DEPTH*DATA_W-1:0]  mem_o
);

  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [DATA_W-1:0]        mem_d [DEPTH];
  logic [NUM_CH*DATA_W-1:0] rd_q;

  // Channels are applied in ascending order so the highest index wins a collision.
  always_comb begin
    mem_d = mem_q;
    if (cp_en_i) begin
      mem_d[cp_addr_i] = cp_data_i;
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (wr_en_i[ch]) begin
        mem_d[wr_addr_i[ch*AW +: AW]] = wr_data_i[ch*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
      rd_q <= '0;
    end else begin
      mem_q <= mem_d;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        rd_q[ch*DATA_W +: DATA_W] <= mem_q[rd_addr_i[ch*AW +: AW]];
      end
    end
  end

  assign rd_data_o = rd_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_flat
    assign mem_o[k*DATA_W +: DATA_W] = mem_q[k];
  end

endmodule

// File: rtl/maxnet_data_mem.sv
// Double-banked MAXNET activation memory with LOAD/RUN/SYNC sequencing.
// Optional MAXNET_DM_NZ_DETECT_EN adds a nonzero-entry counter and winner flag.
module maxnet_data_mem
  import maxnet_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned NUM_CH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_valid_i,
  input  logic [DATA_W-1:0]        ld_data_i,
  output logic                     ld_ready_o,
  input  logic                     reload_i,
  input  logic [NUM_CH*AW-1:0]     rd_addr_i,
  output logic [NUM_CH*DATA_W-1:0] rd_data_o,
  input  logic [NUM_CH-1:0]        wr_en_i,
  input  logic [NUM_CH*AW-1:0]     wr_addr_i,
  input  logic [NUM_CH*DATA_W-1:0] wr_data_i,
  input  logic                     swap_i,
  output logic                     loaded_o,
  output logic                     busy_o
`ifdef MAXNET_DM_NZ_DETECT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] nz_cnt_o,
  output logic                       single_nz_o
`endif
);

  state_e  state_q, state_d;
  logic    act_q, act_d;
  logic    rd_sel_q;
  logic [AW-1:0] ld_ptr_q, ld_ptr_d;
  logic [AW-1:0] cp_ptr_q, cp_ptr_d;

  logic [NUM_CH*DATA_W-1:0] rd_a, rd_b;
  logic [DEPTH*DATA_W-1:0]  mem_a, mem_b, act_mem;
  logic [NUM_CH-1:0]        wr_en_a, wr_en_b;
  logic                     cp_en_a, cp_en_b;
  logic [AW-1:0]            cp_addr;
  logic [DATA_W-1:0]        cp_data;
  logic                     ld_fire, in_run;

  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    ld_ptr_d   = ld_ptr_q;
    cp_ptr_d   = cp_ptr_q;
    ld_ready_o = 1'b0;
    unique case (state_q)
      StLoad: begin
        ld_ready_o = 1'b1;
        if (ld_valid_i) begin
          if (ld_ptr_q == AW'(DEPTH - 1)) begin
            state_d = StRun;
          end else begin
            ld_ptr_d = ld_ptr_q + AW'(1);
          end
        end
      end
      StRun: begin
        // Reload outranks swap and leaves the bank select untouched.
        if (reload_i) begin
          state_d  = StLoad;
          ld_ptr_d = '0;
        end else if (swap_i) begin
          state_d  = StSync;
          act_d    = ~act_q;
          cp_ptr_d = '0;
        end
      end
      StSync: begin
        if (cp_ptr_q == AW'(DEPTH - 1)) begin
          state_d  = StRun;
          cp_ptr_d = '0;
        end else begin
          cp_ptr_d = cp_ptr_q + AW'(1);
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StLoad;
      act_q    <= 1'b0;
      rd_sel_q <= 1'b0;
      ld_ptr_q <= '0;
      cp_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      act_q    <= act_d;
      rd_sel_q <= act_q;
      ld_ptr_q <= ld_ptr_d;
      cp_ptr_q <= cp_ptr_d;
    end
  end

  assign loaded_o = (state_q == StRun);
  assign busy_o   = (state_q == StLoad) || (state_q == StSync);

  // The copy port doubles as the load port: loads hit both banks, SYNC hits the shadow.
  assign ld_fire = (state_q == StLoad) && ld_valid_i;
  assign in_run  = (state_q == StRun);
  assign act_mem = act_q ? mem_b : mem_a;
  assign cp_addr = (state_q == StLoad) ? ld_ptr_q : cp_ptr_q;
  assign cp_data = (state_q == StLoad) ? ld_data_i : act_mem[cp_ptr_q*DATA_W +: DATA_W];
  assign cp_en_a = ld_fire || ((state_q == StSync) && act_q);
  assign cp_en_b = ld_fire || ((state_q == StSync) && !act_q);
  assign wr_en_a = (in_run && act_q) ? wr_en_i : '0;
  assign wr_en_b = (in_run && !act_q) ? wr_en_i : '0;

  maxnet_dm_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .NUM_CH (NUM_CH),
    .AW     (AW)
  ) u_bank_a (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en_a),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .cp_en_i   (cp_en_a),
    .cp_addr_i (cp_addr),
    .cp_data_i (cp_data),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_a),
    .mem_o     (mem_a)
  );

  maxnet_dm_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .NUM_CH (NUM_CH),
    .AW     (AW)
  ) u_bank_b (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en_b),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .cp_en_i   (cp_en_b),
    .cp_addr_i (cp_addr),
    .cp_data_i (cp_data),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_b),
    .mem_o     (mem_b)
  );

  // Both banks register every read; pick the one that was active at the sampling edge.
  assign rd_data_o = rd_sel_q ? rd_b : rd_a;

`ifdef MAXNET_DM_NZ_DETECT_EN
  localparam int unsigned NzW = $clog2(DEPTH + 1);

  logic [NzW-1:0] nz_q, nz_d;

  always_comb begin
    nz_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (act_mem[k*DATA_W +: DATA_W] != '0) begin
        nz_d = nz_d + NzW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nz_q <= '0;
    end else begin
      nz_q <= nz_d;
    end
  end

  assign nz_cnt_o    = nz_q;
  assign single_nz_o = (nz_q == NzW'(1));
`endif

endmodule

// File: tb/tb_maxnet_data_mem.sv
// Directed plus randomized bench for maxnet_data_mem against an active/shadow image model.
module tb_maxnet_data_mem;

  localparam int DW = 32;
  localparam int DP = 4;
  localparam int NC = 4;
  localparam int AW = 2;
  localparam int VW = NC * DW;

  logic              clk;
  logic              rst;
  logic              ld_valid;
  logic [DW-1:0]     ld_data;
  logic              ld_ready;
  logic              reload;
  logic [NC*AW-1:0]  rd_addr;
  logic [VW-1:0]     rd_data;
  logic [NC-1:0]     wr_en;
  logic [NC*AW-1:0]  wr_addr;
  logic [VW-1:0]     wr_data;
  logic              swap;
  logic              loaded;
  logic              busy;
`ifdef MAXNET_DM_NZ_DETECT_EN
  logic [$clog2(DP+1)-1:0] nz_cnt;
  logic                    single_nz;
`endif

  maxnet_data_mem #(
    .DATA_W (DW),
    .DEPTH  (DP),
    .NUM_CH (NC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_valid_i (ld_valid),
    .ld_data_i  (ld_data),
    .ld_ready_o (ld_ready),
    .reload_i   (reload),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .swap_i     (swap),
    .loaded_o   (loaded),
    .busy_o     (busy)
`ifdef MAXNET_DM_NZ_DETECT_EN
    ,
    .nz_cnt_o    (nz_cnt),
    .single_nz_o (single_nz)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: what reads see (active) and what writes build up (shadow).
  logic [DW-1:0] act_img [DP];
  logic [DW-1:0] sh_img  [DP];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] read_vec(input logic [NC*AW-1:0] addrs);
    logic [VW-1:0] v;
    for (int ch = 0; ch < NC; ch++) begin
      v[ch*DW +: DW] = act_img[addrs[ch*AW +: AW]];
    end
    return v;
  endfunction

  task automatic read_chk(input string tag, input logic [NC*AW-1:0] addrs);
    logic [VW-1:0] exp;
    exp     = read_vec(addrs);
    rd_addr = addrs;
    step();
    chk(tag, rd_data, exp);
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < DP; a++) begin
      logic [NC*AW-1:0] addrs;
      for (int ch = 0; ch < NC; ch++) addrs[ch*AW +: AW] = AW'((a + ch) % DP);
      read_chk(tag, addrs);
    end
  endtask

  task automatic load_word(input logic [DW-1:0] w);
    ld_valid = 1'b1;
    ld_data  = w;
    step();
    ld_valid = 1'b0;
  endtask

  task automatic load_all(input string tag, input logic [DW-1:0] w0, w1, w2, w3);
    logic [DW-1:0] ws [DP];
    ws[0] = w0; ws[1] = w1; ws[2] = w2; ws[3] = w3;
    for (int i = 0; i < DP; i++) begin
      load_word(ws[i]);
      chk({tag, "_loaded"}, VW'(loaded), VW'(i == DP - 1));
      act_img[i] = ws[i];
      sh_img[i]  = ws[i];
    end
    chk({tag, "_ready"}, VW'(ld_ready), '0);
  endtask

  // Called just after the swap edge: busy must stay high for exactly DEPTH samples.
  task automatic wait_sync(input string tag);
    int cnt;
    cnt = 0;
    while (busy && cnt < 50) begin
      cnt++;
      step();
    end
    chk({tag, "_busy_cycles"}, VW'(cnt), VW'(DP));
    chk({tag, "_loaded"}, VW'(loaded), VW'(1));
  endtask

  task automatic do_swap(input string tag);
    swap = 1'b1;
    step();
    swap = 1'b0;
    for (int k = 0; k < DP; k++) act_img[k] = sh_img[k];
    wait_sync(tag);
  endtask

  task automatic rand_cycle(input bit swap_now);
    logic [NC-1:0]    en;
    logic [NC*AW-1:0] wa, ra;
    logic [VW-1:0]    wd, exp;
    en = NC'($urandom);
    wa = (NC*AW)'($urandom);
    ra = (NC*AW)'($urandom);
    for (int ch = 0; ch < NC; ch++) wd[ch*DW +: DW] = $urandom_range(0, 255);
    exp     = read_vec(ra);
    wr_en   = en;
    wr_addr = wa;
    wr_data = wd;
    rd_addr = ra;
    swap    = swap_now;
    step();
    wr_en = '0;
    swap  = 1'b0;
    for (int ch = 0; ch < NC; ch++) begin
      if (en[ch]) sh_img[wa[ch*AW +: AW]] = wd[ch*DW +: DW];
    end
    chk("rand_rd", rd_data, exp);
    if (swap_now) begin
      for (int k = 0; k < DP; k++) act_img[k] = sh_img[k];
      wait_sync("rand_swap");
    end
  endtask

  initial begin
    rst      = 1'b1;
    ld_valid = 1'b0;
    ld_data  = '0;
    reload   = 1'b0;
    rd_addr  = '0;
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    swap     = 1'b0;
    for (int k = 0; k < DP; k++) begin
      act_img[k] = '0;
      sh_img[k]  = '0;
    end
    #12;
    chk("rst_loaded", VW'(loaded), '0);
    chk("rst_busy", VW'(busy), VW'(1));
    chk("rst_ready", VW'(ld_ready), VW'(1));
    chk("rst_rd", rd_data, '0);
`ifdef MAXNET_DM_NZ_DETECT_EN
    chk("rst_nz", VW'(nz_cnt), '0);
    chk("rst_single", VW'(single_nz), '0);
`endif
    rst = 1'b0;
    step();

    // Basic load and ordered read-back.
    load_all("load1", 5, 3, 7, 1);
    read_chk("rd_3210", {2'd3, 2'd2, 2'd1, 2'd0});
    chk("rd_3210_lit", rd_data, {32'd1, 32'd7, 32'd3, 32'd5});

    // Shadow write invisible until swap.
    wr_en   = 4'b0001;
    wr_addr = {2'd0, 2'd0, 2'd0, 2'd2};
    wr_data = {32'd0, 32'd0, 32'd0, 32'd9};
    step();
    wr_en     = '0;
    sh_img[2] = 9;
    read_chk("pre_swap_addr2", {2'd2, 2'd2, 2'd2, 2'd2});
    chk("pre_swap_lit", rd_data[DW-1:0], VW'(7));
    do_swap("swap1");
    read_chk("post_swap_addr2", {2'd2, 2'd2, 2'd2, 2'd2});
    chk("post_swap_lit", rd_data[DW-1:0], VW'(9));

    // Write-free swap: shadow must already mirror the active bank.
    do_swap("swap_nowr");
    read_all("nowr_rd");

    // Collision: highest channel wins.
    wr_en   = 4'b1010;
    wr_addr = {2'd0, 2'd0, 2'd0, 2'd0};
    wr_data = {32'd6, 32'd0, 32'd4, 32'd0};
    step();
    wr_en     = '0;
    sh_img[0] = 6;
    do_swap("swap_coll");
    read_chk("coll_addr0", '0);
    chk("coll_lit", rd_data[DW-1:0], VW'(6));

    // Randomized RUN traffic with swaps, some carrying same-cycle writes.
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(2, 5);
      for (int c = 0; c < n; c++) rand_cycle(1'b0);
      rand_cycle(1'b1);
      read_all("rand_post");
    end

    // Swap and reload together: reload wins, contents kept.
    reload = 1'b1;
    swap   = 1'b1;
    step();
    reload = 1'b0;
    swap   = 1'b0;
    chk("reload_busy", VW'(busy), VW'(1));
    chk("reload_loaded", VW'(loaded), '0);
    read_chk("reload_keep", {2'd3, 2'd2, 2'd1, 2'd0});
    // Swap and writes in LOAD are ignored.
    swap    = 1'b1;
    wr_en   = 4'b1111;
    wr_addr = {2'd3, 2'd2, 2'd1, 2'd0};
    wr_data = {32'hAA, 32'hBB, 32'hCC, 32'hDD};
    step();
    swap  = 1'b0;
    wr_en = '0;
    chk("load_swap_ign", VW'(ld_ready), VW'(1));
    load_all("load2", $urandom_range(1, 999), $urandom_range(1, 999),
             $urandom_range(1, 999), $urandom_range(1, 999));
    read_all("load2_rd");
    do_swap("swap_load2");
    read_all("load2_swap_rd");

    // Reset in the middle of a load.
    reload = 1'b1;
    step();
    reload = 1'b0;
    load_word(32'h11);
    load_word(32'h22);
    #2 rst = 1'b1;
    #1;
    chk("midrst_rd", rd_data, '0);
    chk("midrst_busy", VW'(busy), VW'(1));
    #2 rst = 1'b0;
    for (int k = 0; k < DP; k++) begin
      act_img[k] = '0;
      sh_img[k]  = '0;
    end
    step();
    read_all("midrst_zero");
    load_all("load3", 21, 22, 23, 24);
    read_all("load3_rd");

`ifdef MAXNET_DM_NZ_DETECT_EN
    reload = 1'b1;
    step();
    reload = 1'b0;
    load_all("load_nz", 0, 0, 8, 0);
    step();
    chk("nz_cnt", VW'(nz_cnt), VW'(1));
    chk("single_nz", VW'(single_nz), VW'(1));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/maxnet_data_mem.md
MAXNET_DATA_MEM -- requirements
Module: maxnet_data_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of one neuron activation word.
REQ-002 SHALL have parameter DEPTH, default 4, number of neuron entries; must be at least 2.
REQ-003 SHALL have parameter NUM_CH, default 4, number of parallel read and write channels; must satisfy 1 <= NUM_CH <= DEPTH.
REQ-004 SHALL derive AW = $clog2(DEPTH) as the address width.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 ld_valid  input  1  load word offered.
REQ-008 ld_data  input  DATA_W  load word.
REQ-009 ld_ready  output  1  load word accepted when high together with ld_valid.
REQ-010 reload  input  1  single-cycle pulse; restarts the load sequence.
REQ-011 rd_addr  input  NUM_CH*AW  per-channel read address; channel i occupies bits [i*AW +: AW].
REQ-012 rd_data  output  NUM_CH*DATA_W  per-channel registered read data.
REQ-013 wr_en  input  NUM_CH  per-channel write enable.
REQ-014 wr_addr  input  NUM_CH*AW  per-channel write address.
REQ-015 wr_data  input  NUM_CH*DATA_W  per-channel write data.
REQ-016 swap  input  1  single-cycle pulse; ends the current iteration.
REQ-017 loaded  output  1  high in the RUN state.
REQ-018 busy  output  1  high in the LOAD and SYNC states.

Function
REQ-019 SHALL hold two banks, A and B, of DEPTH x DATA_W words, plus a bank-select bit act; the active bank is the one act selects and the shadow bank is the other.
REQ-020 SHALL implement an FSM with states LOAD, RUN and SYNC.
REQ-021 LOAD: ld_ready = 1; each accepted word is written to both banks at ld_ptr, and ld_ptr increments; the DEPTH-th accepted word moves the FSM to RUN on the same edge.
REQ-022 RUN: ld_ready = 0; a reload pulse moves the FSM to LOAD with ld_ptr = 0, and bank contents are kept until they are overwritten.
REQ-023 SHALL return rd_data[i] = active[rd_addr[i]] registered, with 1-cycle latency, in every state.
REQ-024 In RUN, wr_en[i] SHALL write wr_data[i] to shadow[wr_addr[i]]; in LOAD and SYNC, writes are ignored.
REQ-025 On an address collision between channels in the same cycle, the highest-index channel SHALL win.
REQ-026 Reads SHALL never observe same-cycle writes, because writes go to the shadow bank only.
REQ-027 swap in RUN SHALL toggle act and enter SYNC; writes in the same cycle land in the old shadow bank, which becomes active.
REQ-028 SYNC SHALL copy new active[k] to new shadow[k] for k = 0..DEPTH-1, one entry per cycle, taking DEPTH cycles, then return to RUN.
REQ-029 swap or reload received in LOAD or SYNC SHALL be ignored.
REQ-030 If swap and reload coincide in RUN, reload SHALL take priority and act is unchanged.
REQ-031 ld_ptr wrap-around is not reachable; the counter SHALL saturate at DEPTH-1.

Reset
REQ-032 rst SHALL clear both banks to 0 and set act = 0, ld_ptr = 0, copy pointer = 0, state = LOAD, rd_data = 0, loaded = 0 and busy = 1.
REQ-033 rst mid-LOAD or mid-SYNC SHALL discard progress and restart LOAD from entry 0.

Configuration
REQ-034 Macro MAXNET_DM_NZ_DETECT_EN, when defined, SHALL add output nz_cnt ($clog2(DEPTH+1) bits, count of nonzero active entries, registered and updated every cycle) and output single_nz (nz_cnt == 1, the winner-found flag).
REQ-035 Without MAXNET_DM_NZ_DETECT_EN, these ports and their logic SHALL be absent.
REQ-036 nz_cnt and single_nz SHALL reset to 0.

Structure
REQ-037 Package maxnet_pkg SHALL hold the FSM state enum (LOAD, RUN, SYNC) and the default DATA_W constant.
REQ-038 Sub-module maxnet_dm_bank (single DEPTH x DATA_W array, NUM_CH write ports, one copy-write port, NUM_CH registered read ports) SHALL be instantiated twice.

Verification
REQ-039 Reset, then load 5, 3, 7, 1 -> loaded rises after the 4th accepted word; rd_addr = {3, 2, 1, 0} returns {1, 7, 3, 5} one cycle later.
REQ-040 In RUN, write ch0 addr 2 = 9 -> reads of addr 2 stay 7 until swap; after swap, addr 2 reads 9.
REQ-041 Assert swap -> busy is high for exactly 4 cycles; afterwards the shadow bank equals the active bank, checked by a write-free swap that leaves all reads unchanged.
REQ-042 ch1 and ch3 both write addr 0 (values 4 and 6) in one cycle, then swap -> addr 0 reads 6.
REQ-043 Assert rst after 2 load words -> all reads return 0, ld_ptr restarts, and 4 new words are required before loaded rises.
REQ-044 With MAXNET_DM_NZ_DETECT_EN, load 0, 0, 8, 0 -> nz_cnt = 1 and single_nz = 1.
